serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits; legal range 1..32.
REQ-002 SHALL have port clk  input  1  the single clock, rising-edge active.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  operand A, unsigned or two's complement.
REQ-006 SHALL have port b  input  WIDTH  operand B.
REQ-007 SHALL have port cin  input  1  carry-in.
REQ-008 SHALL have port busy  output  1  high while bits are being processed.
REQ-009 SHALL have port done  output  1  one-cycle pulse when sum/cout become valid.
REQ-010 SHALL have port sum  output  WIDTH  registered result, low WIDTH bits of a+b+cin.
REQ-011 SHALL have port cout  output  1  registered carry-out of bit WIDTH-1.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-013 IDLE with start=1 at a rising edge SHALL capture a, b and cin into internal registers, clear the bit counter and go to RUN.
REQ-014 IDLE with start=0 SHALL remain in IDLE.
REQ-015 RUN SHALL process one bit per cycle, LSB first, through a single full-adder cell: s = ai^bi^c, c' = ai&bi | c&(ai^bi).
REQ-016 Each RUN cycle SHALL shift s into an internal result shift register from the MSB end, update the carry register and increment the counter.
REQ-017 After the edge that processes bit WIDTH-1, the FSM SHALL go to DONE and load sum and cout from the internal registers in the same edge.
REQ-018 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-019 Latency: with start sampled at edge E0, done SHALL be high from edge E0+WIDTH to edge E0+WIDTH+1.
REQ-020 busy SHALL be high exactly in RUN (WIDTH cycles), and low in IDLE and DONE.
REQ-021 start SHALL be ignored in RUN and DONE; operands captured at E0 SHALL NOT change mid-operation.
REQ-022 Input changes on a, b and cin after E0 SHALL NOT affect the result.
REQ-023 sum and cout SHALL hold the previous result throughout RUN and after DONE until the next completion.
REQ-024 WIDTH=1 SHALL be supported: one RUN cycle, then DONE.
REQ-025 The counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap during an operation.

Reset
REQ-026 On rst_n=0 the block SHALL asynchronously force state=IDLE, busy=0, done=0, sum=0, cout=0, and clear the counter, carry and shift registers.
REQ-027 Reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL be issued for it.
REQ-028 After rst_n deasserts, the first start SHALL be accepted at the first rising edge on which it is high.

Configuration
REQ-029 Macro SERIAL_ADDER_OVF_EN defined SHALL add port ovf  output  1  registered signed overflow, equal to (carry into bit WIDTH-1) XOR cout.
REQ-030 ovf SHALL load together with sum/cout, reset to 0, and hold like sum.
REQ-031 Without SERIAL_ADDER_OVF_EN, the ovf port and its logic SHALL NOT exist; all other behaviour SHALL be identical.

Verification
REQ-032 Test WIDTH=8, a=0x00, b=0x00, cin=0, start at E0: busy high for 8 cycles, done at E0+8, sum=0x00, cout=0.
REQ-033 Test WIDTH=8, a=0xFF, b=0x01, cin=0: sum=0x00, cout=1; then a=0xA5, b=0x5A, cin=1: sum=0x00, cout=1.
REQ-034 Test WIDTH=8 with SERIAL_ADDER_OVF_EN, a=0x7F, b=0x01: sum=0x80, cout=0, ovf=1; a=0x80, b=0x80: sum=0x00, cout=1, ovf=1.
REQ-035 Test start pulsed at E0+3 during RUN and a changed mid-run: ignored; done still at E0+8 with the original-operand result; sum holds the old value until E0+8.
REQ-036 Test rst_n low at E0+4: busy=0, sum=0 immediately; no done; the next start completes normally.
REQ-037 Test WIDTH=1, a=1, b=1, cin=1: done at E0+1, sum=1, cout=1.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell processes a+b+cin LSB first, WIDTH cycles per add.
// Optional macro SERIAL_ADDER_OVF_EN adds a registered signed-overflow output (ovf).
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_capture;
    logic             w_step;
    logic             w_last;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_c;
    logic [WIDTH-1:0] r_res;
    logic [CNT_W-1:0] r_cnt;

    logic             w_ai;
    logic             w_bi;
    logic             w_p;
    logic             w_s;
    logic             w_c_nxt;
    logic [WIDTH-1:0] w_res_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_step      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_step = 1'b1;
                if (r_cnt == LAST_BIT) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);

    // Single full-adder cell; operand registers shift right so bit 0 is always the current bit.
    assign w_ai    = r_a[0];
    assign w_bi    = r_b[0];
    assign w_p     = w_ai ^ w_bi;
    assign w_s     = w_p ^ r_c;
    assign w_c_nxt = (w_ai & w_bi) | (r_c & w_p);

    always_comb begin
        w_res_nxt            = r_res >> 1;
        w_res_nxt[WIDTH-1]   = w_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_c   <= 1'b0;
            r_res <= '0;
            r_cnt <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            if (w_capture) begin
                r_a   <= a;
                r_b   <= b;
                r_c   <= cin;
                r_cnt <= '0;
            end else if (w_step) begin
                r_a   <= r_a >> 1;
                r_b   <= r_b >> 1;
                r_c   <= w_c_nxt;
                r_res <= w_res_nxt;
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_last) begin
                sum  <= w_res_nxt;
                cout <= w_c_nxt;
            end
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // On the last step r_c is the carry into the MSB, w_c_nxt the carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (w_last) begin
            ovf <= r_c ^ w_c_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: WIDTH=8 and WIDTH=1 instances, directed and random adds.
module tb_serial_adder;

    typedef struct {
        int          e0;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start1, cin1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf8, ovf1;
`endif

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t q8[$];
    exp_t q1[$];
    exp_t last8, last1;
    exp_t m8, m1;
    logic eb8, ed8, eb1, ed1;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf8)
`endif
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(input int w, input longint a, input longint b,
                                   input longint c, input int e0);
        exp_t   r;
        longint one, tot, sa, sb, st;
        one   = 1;
        tot   = a + b + c;
        r.e0  = e0;
        r.sum = 32'(tot % (one << w));
        r.cout = (tot >= (one << w));
        sa    = (a >= (one << (w - 1))) ? a - (one << w) : a;
        sb    = (b >= (one << (w - 1))) ? b - (one << w) : b;
        st    = sa + sb + c;
        r.ovf = (st > (one << (w - 1)) - 1) || (st < -(one << (w - 1)));
        return r;
    endfunction

    task automatic issue8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                          output int e0);
        int guard = 0;
        while (q8.size() != 0 && guard < 50) begin
            @(posedge clk); #2;
            guard++;
        end
        if (q8.size() != 0) begin
            chk("idle8_wait", q8.size(), 0);
            q8.delete();
        end
        a8 = ia; b8 = ib; cin8 = ic; start8 = 1'b1;
        e0 = cyc + 1;
        q8.push_back(model(8, ia, ib, ic, e0));
        @(posedge clk); #2;
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    endtask

    task automatic issue1(input logic ia, input logic ib, input logic ic);
        int guard = 0;
        while (q1.size() != 0 && guard < 50) begin
            @(posedge clk); #2;
            guard++;
        end
        if (q1.size() != 0) begin
            chk("idle1_wait", q1.size(), 0);
            q1.delete();
        end
        a1 = ia; b1 = ib; cin1 = ic; start1 = 1'b1;
        q1.push_back(model(1, ia, ib, ic, cyc + 1));
        @(posedge clk); #2;
        start1 = 1'b0;
        a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            eb8 = 1'b0; ed8 = 1'b0;
            if (q8.size() > 0) begin
                m8  = q8[0];
                eb8 = (cyc >= m8.e0) && (cyc < m8.e0 + 8);
                ed8 = (cyc == m8.e0 + 8);
            end
            chk("busy8", busy8, eb8);
            chk("done8", done8, ed8);
            if (ed8) begin
                chk("sum8", sum8, m8.sum);
                chk("cout8", cout8, m8.cout);
`ifdef SERIAL_ADDER_OVF_EN
                chk("ovf8", ovf8, m8.ovf);
`endif
                last8 = m8;
                void'(q8.pop_front());
            end else begin
                chk("sum8_hold", sum8, last8.sum);
                chk("cout8_hold", cout8, last8.cout);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            eb1 = 1'b0; ed1 = 1'b0;
            if (q1.size() > 0) begin
                m1  = q1[0];
                eb1 = (cyc == m1.e0);
                ed1 = (cyc == m1.e0 + 1);
            end
            chk("busy1", busy1, eb1);
            chk("done1", done1, ed1);
            if (ed1) begin
                chk("sum1", sum1, m1.sum);
                chk("cout1", cout1, m1.cout);
`ifdef SERIAL_ADDER_OVF_EN
                chk("ovf1", ovf1, m1.ovf);
`endif
                last1 = m1;
                void'(q1.pop_front());
            end else begin
                chk("sum1_hold", sum1, last1.sum);
                chk("cout1_hold", cout1, last1.cout);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int e0;
        int guard;
        last8 = '{e0: 0, sum: 0, cout: 1'b0, ovf: 1'b0};
        last1 = last8;
        start8 = 0; a8 = 0; b8 = 0; cin8 = 0;
        start1 = 0; a1 = 0; b1 = 0; cin1 = 0;
        rst_n  = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_busy8", busy8, 0);
        chk("rst_done8", done8, 0);
        chk("rst_sum8", sum8, 0);
        chk("rst_cout8", cout8, 0);
        chk("rst_busy1", busy1, 0);
        chk("rst_sum1", sum1, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        issue8(8'h00, 8'h00, 1'b0, e0);
        issue8(8'hFF, 8'h01, 1'b0, e0);
        issue8(8'hA5, 8'h5A, 1'b1, e0);
        issue8(8'h7F, 8'h01, 1'b0, e0);
        issue8(8'h80, 8'h80, 1'b0, e0);

        // Start pulse and operand change in the middle of a run must be ignored.
        issue8(8'h3C, 8'h4B, 1'b1, e0);
        while (cyc < e0 + 2) begin @(posedge clk); #2; end
        start8 = 1'b1; a8 = ~a8; b8 = 8'hFF;
        @(posedge clk); #2;
        start8 = 1'b0;

        // Reset in the middle of a run aborts it.
        issue8(8'h12, 8'h34, 1'b0, e0);
        while (cyc < e0 + 3) begin @(posedge clk); #2; end
        rst_n = 1'b0;
        #1;
        chk("abort_busy8", busy8, 0);
        chk("abort_done8", done8, 0);
        chk("abort_sum8", sum8, 0);
        chk("abort_cout8", cout8, 0);
        q8.delete();
        last8 = '{e0: 0, sum: 0, cout: 1'b0, ovf: 1'b0};
        last1 = last8;
        @(posedge clk); #2;
        rst_n = 1'b1;
        issue8(8'hC8, 8'h64, 1'b1, e0);

        for (int i = 0; i < 12; i++) begin
            issue8(8'($urandom), 8'($urandom), 1'($urandom), e0);
        end

        issue1(1'b1, 1'b1, 1'b1);
        issue1(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            issue1(1'($urandom), 1'($urandom), 1'($urandom));
        end

        guard = 0;
        while ((q8.size() != 0 || q1.size() != 0) && guard < 50) begin
            @(posedge clk); #2;
            guard++;
        end
        chk("drain", q8.size() + q1.size(), 0);
        repeat (3) @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
